// File: rtl/dsp_mac_pipe.sv
// Parametrised multiply-accumulate slice: A*B product pipeline, X/Y/Z operand select, P feedback.
// Build option: define DSP_MAC_PIPE_CASCADE_EN to add the PCIN_i/PCOUT_o cascade ports.
module dsp_mac_pipe #(
    parameter int A_WIDTH   = 17,
    parameter int B_WIDTH   = 17,
    parameter int C_WIDTH   = 34,
    parameter int P_WIDTH   = 48,
    parameter int OUT_WIDTH = 34,
    parameter int ABREG     = 1,
    parameter int MREG      = 1,
    parameter int CREG      = 1,
    parameter int SHIFT     = 17
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic                 CREG_en_i,
    input  logic [6:0]           OPMODE_i,
    input  logic [A_WIDTH-1:0]   A_i,
    input  logic [B_WIDTH-1:0]   B_i,
    input  logic [C_WIDTH-1:0]   C_i,
`ifdef DSP_MAC_PIPE_CASCADE_EN
    input  logic [P_WIDTH-1:0]   PCIN_i,
    output logic [P_WIDTH-1:0]   PCOUT_o,
`endif
    output logic [OUT_WIDTH-1:0] P_o,
    output logic                 valid_o,
    output logic                 opmode_err_o
);

    localparam int D    = ABREG + MREG;
    localparam int DN   = (D > 0) ? D : 1;
    localparam int AB_W = A_WIDTH + B_WIDTH;

    // A/B travel the full ABREG+MREG depth so {A,B} reaches the ALU with its product.
    logic [A_WIDTH-1:0] a_q  [DN];
    logic [B_WIDTH-1:0] b_q  [DN];
    logic [6:0]         op_q [DN];
    logic [DN-1:0]      vld_q;

    logic [A_WIDTH-1:0] a_mul, a_alu;
    logic [B_WIDTH-1:0] b_mul, b_alu;
    logic [6:0]         op_alu;
    logic               vld_alu;
    logic [AB_W-1:0]    m_comb, m_alu;
    logic [C_WIDTH-1:0] c_alu;

    logic [P_WIDTH-1:0] p_q, p_d;
    logic [P_WIDTH-1:0] x_sel, y_sel, z_sel;
    logic               err_d, err_q, vld_o_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < DN; i++) begin
                a_q[i]  <= '0;
                b_q[i]  <= '0;
                op_q[i] <= '0;
                vld_q[i] <= 1'b0;
            end
        end else begin
            a_q[0]   <= A_i;
            b_q[0]   <= B_i;
            op_q[0]  <= OPMODE_i;
            vld_q[0] <= valid_i;
            for (int i = 1; i < DN; i++) begin
                a_q[i]   <= a_q[i-1];
                b_q[i]   <= b_q[i-1];
                op_q[i]  <= op_q[i-1];
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    generate
        if (ABREG == 0) begin : g_ab_comb
            assign a_mul = A_i;
            assign b_mul = B_i;
        end else begin : g_ab_reg
            assign a_mul = a_q[ABREG-1];
            assign b_mul = b_q[ABREG-1];
        end

        if (D == 0) begin : g_alu_comb
            assign a_alu   = A_i;
            assign b_alu   = B_i;
            assign op_alu  = OPMODE_i;
            assign vld_alu = valid_i;
        end else begin : g_alu_reg
            assign a_alu   = a_q[D-1];
            assign b_alu   = b_q[D-1];
            assign op_alu  = op_q[D-1];
            assign vld_alu = vld_q[D-1];
        end

        if (MREG == 1) begin : g_mreg
            logic [AB_W-1:0] m_q;
            always_ff @(posedge clock_i) begin
                if (reset_i) m_q <= '0;
                else         m_q <= m_comb;
            end
            assign m_alu = m_q;
        end else begin : g_mcomb
            assign m_alu = m_comb;
        end

        if (CREG == 1) begin : g_creg
            // The first stage holds unless enabled; the remaining stages always shift.
            logic [C_WIDTH-1:0] c_q [DN];
            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    for (int i = 0; i < DN; i++) c_q[i] <= '0;
                end else begin
                    if (CREG_en_i) c_q[0] <= C_i;
                    for (int i = 1; i < DN; i++) c_q[i] <= c_q[i-1];
                end
            end
            assign c_alu = c_q[DN-1];
        end else begin : g_ccomb
            assign c_alu = C_i;
        end
    endgenerate

    assign m_comb = AB_W'(a_mul) * AB_W'(b_mul);

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        z_sel = '0;
        err_d = (op_alu[3:2] == 2'b10) || (op_alu[6:4] == 3'b100) || (op_alu[6:4] == 3'b111)
             || ((op_alu[1:0] == 2'b01) != (op_alu[3:2] == 2'b01));
`ifndef DSP_MAC_PIPE_CASCADE_EN
        err_d = err_d || (op_alu[6:4] == 3'b001) || (op_alu[6:4] == 3'b101);
`endif
        // X=01/Y=01 together select the product once; Y's half contributes nothing.
        case (op_alu[1:0])
            2'b01:   x_sel = P_WIDTH'(m_alu);
            2'b10:   x_sel = p_q;
            2'b11:   x_sel = P_WIDTH'({a_alu, b_alu});
            default: x_sel = '0;
        endcase
        if (op_alu[3:2] == 2'b11) y_sel = P_WIDTH'(c_alu);
        case (op_alu[6:4])
`ifdef DSP_MAC_PIPE_CASCADE_EN
            3'b001:  z_sel = PCIN_i;
            3'b101:  z_sel = PCIN_i >> SHIFT;
`endif
            3'b010:  z_sel = p_q;
            3'b011:  z_sel = P_WIDTH'(c_alu);
            3'b110:  z_sel = p_q >> SHIFT;
            default: z_sel = '0;
        endcase
        if (err_d) begin
            x_sel = '0;
            y_sel = '0;
            z_sel = '0;
        end
        p_d = x_sel + y_sel + z_sel;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            p_q     <= '0;
            vld_o_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            p_q     <= p_d;
            vld_o_q <= vld_alu;
            err_q   <= err_d;
        end
    end

    assign P_o          = p_q[OUT_WIDTH-1:0];
    assign valid_o      = vld_o_q;
    assign opmode_err_o = err_q;
`ifdef DSP_MAC_PIPE_CASCADE_EN
    assign PCOUT_o      = p_q;
`endif

endmodule
